// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller and its decoder.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned AN_W       = 8;
  localparam int unsigned SEG_W      = 7;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF  = 8'hFF;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  // Per-frame snapshot of the display inputs.
  typedef struct packed {
    logic [NUM_DIGITS*CODE_W-1:0] digits;
    logic [NUM_DIGITS-1:0]        en;
  } shadow_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit code to active-low seven-segment pattern (hex 0-F).
// Stateless; also used by the timer FSM debug path.
module seg_decode
  import seg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (code)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit common-anode scan controller with per-frame input shadowing.
// Anti-ghosting blank phase at each slot start is enabled by `define SEG_SCAN_GUARD_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned GUARD_CYC = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_DIGITS*CODE_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]        digit_en,
  output logic [AN_W-1:0]              anode,
  output logic [SEG_W-1:0]             cathode,
  output logic                         frame_done
);

  localparam int unsigned      CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

`ifdef SEG_SCAN_GUARD_EN
  localparam scan_state_e SLOT_START = BLANK;
`else
  localparam scan_state_e SLOT_START = DRIVE;
`endif

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  shadow_t          shadow_q, shadow_d;
  logic [AN_W-1:0]  anode_q, anode_d;
  logic [SEG_W-1:0] cathode_q, cathode_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end_c;
  logic             frame_end_c;
  logic [SEG_W-1:0] seg_c;

  seg_decode u_decode (
    .code  (shadow_q.digits[{idx_q, 2'b00} +: CODE_W]),
    .seg_c (seg_c)
  );

  // Next-state, slot timing, shadow capture and output patterns.
  always_comb begin
    slot_end_c   = (cnt_q == CNT_LAST);
    frame_end_c  = slot_end_c && (idx_q == IDX_LAST);
    state_d      = state_q;
    cnt_d        = slot_end_c ? '0 : cnt_q + CNT_W'(1);
    idx_d        = slot_end_c ? idx_q + IDX_W'(1) : idx_q;
    shadow_d     = frame_end_c ? '{digits: digits, en: digit_en} : shadow_q;
    anode_d      = AN_OFF;
    cathode_d    = SEG_OFF;
    frame_done_d = frame_end_c;

    case (state_q)
      BLANK: begin
        if (cnt_q == GUARD_LAST) state_d = DRIVE;
      end
      DRIVE: begin
        if (shadow_q.en[idx_q]) anode_d = ~(AN_W'(1) << idx_q);
        cathode_d = seg_c;
        if (slot_end_c) state_d = SLOT_START;
      end
      default: state_d = SLOT_START;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SLOT_START;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      anode_q      <= AN_OFF;
      cathode_q    <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-based display model predicts every output cycle.
// Honours `define SEG_SCAN_GUARD_EN the same way as the design.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 8;
  localparam int GUARD_CYC = 2;
  localparam int FRAME     = 8 * SCAN_DIV;
`ifdef SEG_SCAN_GUARD_EN
  localparam int BLANK_LEN = GUARD_CYC;
`else
  localparam int BLANK_LEN = 0;
`endif

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] ca;
    logic       fd;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        frame_done;

  int   errors = 0;
  int   checks = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  int   t_model = 0;
  obs_t exp_q[$];
  logic [3:0] sh_dig [8];
  logic [7:0] sh_en;

  always #5 clock = ~clock;

  seg_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .digits     (digits),
    .digit_en   (digit_en),
    .anode      (anode),
    .cathode    (cathode),
    .frame_done (frame_done)
  );

  // Reference model: position in the frame derived from elapsed cycles since reset.
  always @(posedge clock) begin : model
    obs_t e;
    int   slot;
    int   pos;
    if (reset) begin
      e = '{an: 8'hFF, ca: 7'h7F, fd: 1'b0};
      t_model = 0;
      sh_en = '0;
      for (int i = 0; i < 8; i++) sh_dig[i] = '0;
    end else begin
      slot = (t_model / SCAN_DIV) % 8;
      pos  = t_model % SCAN_DIV;
      if (pos >= BLANK_LEN) begin
        e.an = sh_en[slot] ? ~(8'(1) << slot) : 8'hFF;
        e.ca = SEG_TBL[sh_dig[slot]];
      end else begin
        e.an = 8'hFF;
        e.ca = 7'h7F;
      end
      e.fd = ((t_model % FRAME) == FRAME - 1);
      if (e.fd) begin
        for (int i = 0; i < 8; i++) sh_dig[i] = digits[i*4 +: 4];
        sh_en = digit_en;
      end
      t_model++;
    end
    exp_q.push_back(e);
    n_push++;
  end

  // Monitor: pops one expectation per output cycle.
  always @(negedge clock) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_pop++;
      checks++;
      if ({anode, cathode, frame_done} !== e) begin
        errors++;
        $display("FAIL scan t=%0t: got an=%h ca=%h fd=%b, expected an=%h ca=%h fd=%b",
                 $time, anode, cathode, frame_done, e.an, e.ca, e.fd);
      end
      checks++;
      if ($countones(~anode) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t: anode=%h has more than one low bit", $time, anode);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Advance at least one cycle, then until the model sits at frame offset 'target'.
  task automatic wait_pos(input int target);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while ((t_model % FRAME) != target && k < 3 * FRAME);
    if ((t_model % FRAME) != target) begin
      errors++;
      $display("FAIL wait_pos: offset %0d never reached, at %0d", target, t_model % FRAME);
    end
  endtask

  initial begin : stim
    int n;
    reset    = 1'b1;
    digits   = 32'h7654_3210;
    digit_en = 8'hFF;
    tick(3);
    reset = 1'b0;

    n = 0;
    while (n < 3 * FRAME) begin
      @(posedge clock);
      #1;
      n++;
      if (frame_done) break;
    end
    checks++;
    if (n != FRAME) begin
      errors++;
      $display("FAIL first_frame_done: got %0d cycles after release, expected %0d", n, FRAME);
    end

    tick(FRAME + 4);

    digit_en = 8'b0101_0101;
    digits   = $urandom;
    tick(2 * FRAME);

    digits   = 32'h1111_1111;
    digit_en = 8'hFF;
    wait_pos(0);
    wait_pos(3 * SCAN_DIV);
    digits = 32'h9999_9999;
    tick(2 * FRAME);

    wait_pos(5 * SCAN_DIV + 4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(FRAME + 4);

    repeat (14) begin
      digits   = $urandom;
      digit_en = 8'($urandom);
      tick($urandom_range(5, 90));
      if ($urandom_range(0, 5) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    tick(2 * FRAME);

    @(negedge clock);
    #1;
    checks++;
    if (n_push != n_pop) begin
      errors++;
      $display("FAIL drain: monitor consumed %0d of %0d expectations", n_pop, n_push);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the 8-digit, common-anode seven-segment display driven by the countdown timer. Gives each digit position a fixed slot on the shared `cathode` bus, drives the matching `anode` line, and inserts optional blanking between slots to suppress ghosting. Sits between the timer FSM's digit outputs and the board pins, and is the only block that drives `anode`/`cathode`.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz); must exceed `GUARD_CYC`.
- `GUARD_CYC`, 16: blanking cycles at the start of each slot (used only with the guard feature); ≥1.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `digits` in 32: eight 4-bit codes; nibble i (bits 4i+3:4i) is for digit i.
- `digit_en` in 8: bit i=1 lights digit i; 0 keeps it dark for its slot.
- `anode` out 8: active-low digit select; bit i = digit i.
- `cathode` out 7: active-low segments, order {g,f,e,d,c,b,a}.
- `frame_done` out 1: one-cycle pulse when the digit-7 slot ends.

## Operation
- State machine: BLANK and DRIVE. Slot counter `cnt` runs 0..SCAN_DIV-1. Digit index `idx` runs 0..7.
- BLANK: `anode`=8'hFF and `cathode`=7'h7F. When `cnt`=GUARD_CYC-1, go to DRIVE.
- DRIVE: `anode` = ~(1<<idx) if `digit_en[idx]`, else 8'hFF. `cathode` = decode(shadow[idx]).
- At `cnt`=SCAN_DIV-1: `cnt` goes to 0, `idx` goes to `idx`+1 mod 8, and the state returns to BLANK.
- Shadow register: all 32 bits of `digits` and all 8 bits of `digit_en` are captured when `idx` wraps from 7 to 0. This prevents tearing within a frame. Mid-frame changes to the inputs take effect only at the next frame.
- Decode: 0–9 map to the standard digits and 10–15 map to hex A,b,C,d,E,F. The decode is a pure function with no state.
- A disabled digit still uses its full slot, so duty cycle is identical for every digit.
- `frame_done` pulses in the cycle after the last cycle of the idx=7 slot, which is the same cycle the shadow register is loaded.

## Timing
- Reset values: `anode`=8'hFF, `cathode`=7'h7F, `frame_done`=0, `idx`=0, `cnt`=0, state BLANK.
- After reset, the shadow register holds all zeros and `digit_en`=0, so the display is dark until the first frame wrap.
- Outputs are registered. The output pattern for a cycle reflects the state/`cnt`/`idx` of the previous cycle, which gives a fixed 1-cycle latency.
- Slot length is exactly SCAN_DIV cycles. Frame length is 8·SCAN_DIV cycles. `frame_done` period is 8·SCAN_DIV.
- Reset mid-slot: next cycle returns all reset values. No partial-slot output and no `frame_done` pulse.
- Never more than one `anode` bit is low. Between adjacent lit slots, at least GUARD_CYC cycles of all-high `anode` occur (with the guard feature).

## Configuration
- `SEG_SCAN_GUARD_EN` defined: the BLANK phase is present as described above.
- Not defined:
  - BLANK is bypassed and each slot is DRIVE for all SCAN_DIV cycles.
  - `GUARD_CYC` is ignored.
  - Reset state is DRIVE with idx=0, but outputs still reset to all-high.

## Structure
- Shared package `seg_pkg`:
  - state enum {BLANK, DRIVE}
  - the 16 segment-pattern constants
  - `SEG_OFF`=7'h7F
  - `AN_OFF`=8'hFF
- Sub-module `seg_decode`: combinational 4-bit code to 7-bit active-low pattern. It is reused by the timer FSM's debug path.
- Top level holds the counter, index, shadow register, and FSM.

## Test plan
All scenarios use SCAN_DIV=8 and GUARD_CYC=2.
- Reset held 3 cycles, then released → `anode`=FF, `cathode`=7F, `frame_done`=0 throughout, and the first `frame_done` pulse arrives 64 cycles after release.
- `digits`=32'h7654_3210, `digit_en`=FF, wait one frame → slot i shows `anode`=~(1<<i). Cathode sequence is 40,79,24,30,19,12,02,78, each pattern held 6 cycles after 2 blank cycles.
- `digit_en`=8'b0101_0101 → `anode` goes low only in slots 0,2,4,6, and all 8 slots keep a length of 8 cycles.
- Change `digits` from 1111_1111 to 9999_9999 mid-frame at idx=3 → the rest of the frame still shows "1". "9" (cathode 10) appears from slot 0 of the next frame.
- Assert reset at `cnt`=4, idx=5 → next cycle has all reset values. Resume from idx 0 with no `frame_done` pulse.
- Compile without `SEG_SCAN_GUARD_EN` → every slot lit for all 8 cycles, and `anode` never shows FF between lit slots.
